// File: rtl/idct2d_seq_if.sv
// Handshake bundle for the sequential 2D IDCT: coefficient block in,
// reconstructed sample block out, each side with its own ready/valid pair.
interface idct2d_seq_if #(
  parameter int N = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [N*64-1:0]   data_in;
  logic              out_valid;
  logic              out_ready;
  logic [N*64-1:0]   data_out;

  // Coefficient source / pixel sink side
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out
  );

  // Transform block side
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/idct2d_seq.sv
// Sequential 8x8 inverse DCT. One combinational 8-point IDCT core is reused
// for 8 row passes and then 8 column passes; a transpose buffer sits between
// the passes so both read a contiguous row.

// 8-point inverse DCT, orthonormal scaling, Q12 cosine constants.
// Each output is round-half-up of the Q12 sum, saturated to N bits.
module idct1d #(
  parameter int N = 16
) (
  input  logic [8*N-1:0] i_row,
  output logic [8*N-1:0] o_row
);
  localparam int MAXV = (1 << (N - 1)) - 1;
  localparam int MINV = -(1 << (N - 1));

  // Basis weight 0.5*c(k)*cos((2x+1)k*pi/16) in Q12, folded onto the
  // first quadrant so only eight magnitudes are needed.
  function automatic int f_coef(input int x, input int k);
    int   m;
    int   c;
    logic neg;
    if (k == 0) return 1448;
    m   = ((2 * x + 1) * k) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      1:       c = 2009;
      2:       c = 1892;
      3:       c = 1703;
      4:       c = 1448;
      5:       c = 1138;
      6:       c = 784;
      7:       c = 400;
      default: c = 0;
    endcase
    return neg ? -c : c;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_out
      int          w_acc;
      int          w_rnd;
      logic [N-1:0] w_sat;

      // Dot product of the input row with basis column gi, then round/saturate
      always_comb begin
        w_acc = 0;
        for (int k = 0; k < 8; k++) begin
          w_acc = w_acc + int'($signed(i_row[k*N +: N])) * f_coef(gi, k);
        end
        w_rnd = (w_acc + 2048) >>> 12;
        if (w_rnd > MAXV)      w_sat = N'(MAXV);
        else if (w_rnd < MINV) w_sat = N'(MINV);
        else                   w_sat = w_rnd[N-1:0];
      end

      assign o_row[gi*N +: N] = w_sat;
    end
  endgenerate
endmodule

module idct2d_seq #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst,
  idct2d_seq_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_idx;
  logic                w_in_ready;
  logic                w_out_valid;

  logic signed [N-1:0] r_inbuf  [64];
  logic signed [N-1:0] r_tbuf   [64];
  logic signed [N-1:0] r_outbuf [64];

  logic [8*N-1:0]      w_core_in;
  logic [8*N-1:0]      w_core_out;

  idct1d #(.N(N)) u_core (
    .i_row (w_core_in),
    .o_row (w_core_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state and handshake outputs; outputs depend only on the state
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = S_ROW;
      end
      S_ROW: begin
        if (r_idx == 3'd7) w_state_next = S_COL;
      end
      S_COL: begin
        if (r_idx == 3'd7) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

  genvar gi;
  generate
    // Core reads row idx of the input block in ROW, of the transpose buffer in COL
    for (gi = 0; gi < 8; gi++) begin : g_core_in
      assign w_core_in[gi*N +: N] = (r_state == S_ROW) ? r_inbuf[{r_idx, 3'(gi)}]
                                                       : r_tbuf[{r_idx, 3'(gi)}];
    end
    for (gi = 0; gi < 64; gi++) begin : g_data_out
      assign bus.data_out[gi*N +: N] = r_outbuf[gi];
    end
  endgenerate

  // Buffers and pass counter; results are written transposed so that the
  // column pass and the final output both read/write whole rows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= 3'd0;
      for (int i = 0; i < 64; i++) begin
        r_inbuf[i]  <= '0;
        r_tbuf[i]   <= '0;
        r_outbuf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < 64; i++) r_inbuf[i] <= bus.data_in[i*N +: N];
            r_idx <= 3'd0;
          end
        end
        S_ROW: begin
          for (int k = 0; k < 8; k++) r_tbuf[{3'(k), r_idx}] <= w_core_out[k*N +: N];
          r_idx <= r_idx + 3'd1;
        end
        S_COL: begin
          for (int k = 0; k < 8; k++) r_outbuf[{3'(k), r_idx}] <= w_core_out[k*N +: N];
          r_idx <= r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_idct2d_seq.sv
// Bench for idct2d_seq: golden 2D model (rows then columns of an 8-point
// IDCT with Q12 cosines), expected blocks queued at accept, popped at output.
module tb_idct2d_seq;
  localparam int N = 16;
  localparam int W = N * 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  idct2d_seq_if #(.N(N)) bus ();
  idct2d_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int coef [8][8];
  logic [W-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int core(input int v [8], input int x);
    int acc;
    int r;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += coef[x][k] * v[k];
    r = (acc + 2048) >>> 12;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Y = colpass(rowpass(X)): R[r][x] = core(X[r][*]); Y[x][c] = core(R[*][c])
  function automatic logic [W-1:0] golden(input logic [W-1:0] b);
    int rows [8][8];
    int mid  [8][8];
    int v    [8];
    logic [W-1:0] res;
    res = '0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) rows[r][k] = int'($signed(b[(r*8+k)*N +: N]));
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) v[k] = rows[r][k];
      for (int x = 0; x < 8; x++) mid[r][x] = core(v, x);
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) v[k] = mid[k][c];
      for (int x = 0; x < 8; x++) res[(x*8+c)*N +: N] = 16'(core(v, x));
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rand_block();
    logic [W-1:0] res;
    int t;
    for (int i = 0; i < 64; i++) begin
      t = int'($urandom_range(0, 2047)) - 1024;
      res[i*N +: N] = 16'(t);
    end
    return res;
  endfunction

  // Present a block, wait (bounded) for in_ready, let the accepting edge pass
  task automatic send(input logic [W-1:0] b, input bit push, output bit ok);
    int n;
    bus.data_in  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    ok = (bus.in_ready === 1'b1);
    tick();
    bus.in_valid = 1'b0;
    if (push && ok) exp_q.push_back(golden(b));
  endtask

  // Called in cycle 1 after an accept; returns the cycle out_valid is seen
  task automatic wait_out(output int cyc, output bit saw_ready);
    cyc = 1;
    saw_ready = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 60) begin
      if (bus.in_ready !== 1'b0) saw_ready = 1'b1;
      tick();
      cyc++;
    end
    if (bus.in_ready !== 1'b0) saw_ready = 1'b1;
    if (bus.out_valid !== 1'b1) cyc = -1;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL reset_data_out got=%h want=0", bus.data_out); end
    rst = 1'b0;
    tick();
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
  endtask

  task automatic test_zero();
    bit ok, saw;
    int cyc;
    logic [W-1:0] e;
    send('0, 1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_accept got=timeout want=accept"); end
    wait_out(cyc, saw);
    total++;
    if (cyc !== 17) begin bad++; $display("FAIL zero_latency got=%0d want=17", cyc); end
    total++;
    if (saw) begin bad++; $display("FAIL zero_in_ready_busy got=1 want=0 in cycles 1..17"); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++;
    if (bus.data_out !== e) begin bad++; $display("FAIL zero_data got=%h want=%h", bus.data_out, e); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL zero_all_zero got=%h want=0", bus.data_out); end
    $display("zero block: out at cycle %0d", cyc);
    release_out();
  endtask

  task automatic test_golden();
    bit ok, saw;
    int cyc;
    logic [W-1:0] b, e;
    for (int i = 0; i < 51; i++) begin
      if (i == 0) begin
        b = '0;
        b[N-1:0] = 16'd256;
      end else begin
        b = rand_block();
      end
      send(b, 1'b1, ok);
      wait_out(cyc, saw);
      total++;
      if (cyc !== 17) begin bad++; $display("FAIL golden_latency blk=%0d got=%0d want=17", i, cyc); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      total++;
      if (bus.data_out !== e) begin bad++; $display("FAIL golden_data blk=%0d got=%h want=%h", i, bus.data_out, e); end
      if (i == 0) begin
        // DC 256 -> row pass 91 -> column pass 32 everywhere
        total++;
        if (bus.data_out[0 +: N] !== 16'd32) begin bad++; $display("FAIL dc_elem00 got=%0d want=32", $signed(bus.data_out[0 +: N])); end
        total++;
        if (bus.data_out[63*N +: N] !== 16'd32) begin bad++; $display("FAIL dc_elem77 got=%0d want=32", $signed(bus.data_out[63*N +: N])); end
      end
      $display("golden blk %0d: out at cycle %0d", i, cyc);
      release_out();
    end
  endtask

  task automatic test_backpressure();
    bit ok, saw;
    int cyc;
    logic [W-1:0] e;
    send(rand_block(), 1'b1, ok);
    wait_out(cyc, saw);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.data_out !== e) begin
        bad++;
        $display("FAIL bp_hold k=%0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 k, bus.out_valid, bus.in_ready, bus.data_out, e);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bus.out_valid); end
    $display("backpressure: out at cycle %0d held 5 cycles", cyc);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] blks [3];
    int acc_cyc [3];
    int out_cyc [3];
    int na, no, t;
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      blks[i] = rand_block();
      acc_cyc[i] = -1;
      out_cyc[i] = -1;
    end
    na = 0; no = 0; t = 0;
    bus.out_ready = 1'b1;
    bus.data_in   = blks[0];
    bus.in_valid  = 1'b1;
    while (no < 3 && t < 100) begin
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1 && na < 3) begin
        acc_cyc[na] = t;
        exp_q.push_back(golden(blks[na]));
        na++;
      end
      tick();
      if (na < 3) bus.data_in = blks[na];
      else        bus.in_valid = 1'b0;
      t++;
      if (bus.out_valid === 1'b1) begin
        out_cyc[no] = t;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        total++;
        if (bus.data_out !== e) begin bad++; $display("FAIL b2b_data blk=%0d got=%h want=%h", no, bus.data_out, e); end
        $display("b2b blk %0d: out at cycle %0d", no, t);
        no++;
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_cyc[i] !== 18 * i) begin bad++; $display("FAIL b2b_accept blk=%0d got=%0d want=%0d", i, acc_cyc[i], 18 * i); end
      total++;
      if (out_cyc[i] !== 18 * i + 17) begin bad++; $display("FAIL b2b_out blk=%0d got=%0d want=%0d", i, out_cyc[i], 18 * i + 17); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok, saw;
    int cyc;
    logic [W-1:0] e;
    send(rand_block(), 1'b0, ok);
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", bus.in_ready); end
    total++;
    if (bus.data_out !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", bus.data_out); end
    send(rand_block(), 1'b1, ok);
    wait_out(cyc, saw);
    total++;
    if (cyc !== 17) begin bad++; $display("FAIL rstmid_latency got=%0d want=17", cyc); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++;
    if (bus.data_out !== e) begin bad++; $display("FAIL rstmid_data_after got=%h want=%h", bus.data_out, e); end
    $display("reset mid-op: recovery block out at cycle %0d", cyc);
    release_out();
  endtask

  task automatic test_input_change();
    bit ok, saw;
    int cyc;
    logic [W-1:0] e;
    send(rand_block(), 1'b1, ok);
    bus.data_in = rand_block();
    wait_out(cyc, saw);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    total++;
    if (bus.data_out !== e) begin bad++; $display("FAIL input_change_data got=%h want=%h", bus.data_out, e); end
    $display("input change: out at cycle %0d", cyc);
    release_out();
  endtask

  initial begin
    real s;
    for (int x = 0; x < 8; x++)
      for (int k = 0; k < 8; k++) begin
        s = (k == 0) ? $sqrt(0.5) : 1.0;
        coef[x][k] = int'(2048.0 * s * $cos(3.14159265358979 * real'((2 * x + 1) * k) / 16.0));
      end
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_golden();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idct2d_seq.md
# idct2d_seq

Sequential 8x8 two-dimensional inverse DCT: the decode-side counterpart of the combinational 2D forward DCT. It accepts one coefficient block in the same flat packed format the forward transform produces and returns the reconstructed 8x8 sample block. A single `idct1d` instance is time-multiplexed: 8 row passes, then 8 column passes, with an internal transpose buffer between them. Ready/valid handshakes on both sides let it sit between the coefficient source and the pixel sink in the decode pipeline.

## Interface

**Parameters**
- N, 16, width of each signed element, for coefficients and samples alike.

**Ports**
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in holds a valid coefficient block.
- in_ready  output  1  block can accept a new input block.
- data_in  input  N*64  coefficient block. Element (r,c) is at [(r*8+c)*N +: N]; row r is at [r*8*N +: 8*N].
- out_valid  output  1  data_out holds a completed sample block.
- out_ready  input  1  sink accepts data_out.
- data_out  output  N*64  reconstructed block, same packing as data_in.

## Operation

- **1D core.** Instantiates `idct1d #(.N(N))`. It is combinational, with an 8*N input row and an 8*N output row, element k at [k*N +: N]. This block adds no arithmetic. All scaling, rounding and saturation belong to `idct1d`. Every buffer is N-bit signed with no width growth.
- **Storage.**
  - `inbuf`: 64 elements, loaded on accept.
  - `tbuf`: 64 elements, the transpose buffer.
  - `outbuf`: 64 elements, drives data_out directly.
- **Counter.** `idx`, 3 bits, selects the row or column in progress.
- **FSM states.** IDLE, ROW, COL, DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: inbuf<=data_in, idx<=0, go to ROW.
- **ROW**
  - Core input is inbuf row idx.
  - Core output element k is written to tbuf(k,idx), i.e. transposed on write.
  - idx increments each cycle. When idx==7, go to COL with idx<=0.
- **COL**
  - Core input is tbuf row idx, which is column idx of the row-pass result.
  - Core output element k is written to outbuf(k,idx), transposing back to row-major.
  - When idx==7, go to DONE.
- **DONE**
  - out_valid=1, in_ready=0.
  - On out_ready: go to IDLE.
- **Handshake rules.**
  - in_ready is high only in IDLE.
  - data_in is sampled only on the accepting edge; changes after that have no effect.
  - data_out is stable for as long as out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on rst.
- **Reset.**
  - State <= IDLE, idx <= 0, out_valid=0, in_ready=1 from the first edge with rst high.
  - outbuf, inbuf and tbuf are cleared to 0, so data_out reads 0 after reset.
  - Reset during ROW, COL or DONE aborts the block. No partial output is ever flagged valid.
- **Simultaneous events.**
  - rst has priority over every handshake.
  - in_valid asserted during ROW, COL or DONE is ignored, because in_ready=0. The source must hold it until IDLE.

## Timing

- Cycle 0 is the accepting edge.
- ROW occupies cycles 1..8; COL occupies cycles 9..16.
- out_valid rises after the edge ending cycle 16, so the sink sees it in cycle 17. Latency is 17 cycles from accept to out_valid.
- With out_ready held high:
  - Output handshake occurs in cycle 17.
  - IDLE in cycle 18; next accept possible in cycle 18.
  - Throughput is 1 block per 18 cycles.
- Each cycle of out_ready=0 in DONE adds one cycle.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.

## Test plan

- **All-zero block.** data_in=0 -> out_valid at cycle 17 and data_out=0 in all 64 elements. in_ready=0 during cycles 1..17.
- **Golden match.**
  - Stimulus: DC-only block (element (0,0)=256, others 0), then 50 random blocks with elements in [-1024,1023].
  - Required: data_out bit-exact against a model applying the `idct1d` model to rows, then to columns.
- **Back-pressure.** Hold out_ready=0 for 5 cycles after out_valid -> data_out and out_valid stable throughout, in_ready=0. Handshake occurs on the first out_ready=1 cycle, and in_ready=1 the next cycle.
- **Back-to-back.** in_valid held high with 3 distinct blocks and out_ready=1 -> accepts at cycles 0, 18 and 36. Outputs appear in order at cycles 17, 35 and 53, each matching the golden model.
- **Reset mid-operation.** Assert rst for 1 cycle at cycle 12 (during COL) -> out_valid stays 0, in_ready=1 and data_out=0 the following cycle. A new block accepted afterwards produces a correct result with no residue from the aborted block.
- **Input change after accept.** Change data_in at cycle 1 -> output corresponds only to the block sampled at cycle 0.
